// File: rtl/fir_tdm_mac_engine.sv
// Time-multiplexed FIR, NUM_MAC taps per clock; oFirOut lands ceil(N/NUM_MAC)+1 clocks after an accepted strobe.
// No backpressure: strobes while busy or during coefficient writes are dropped and flagged on oOverrun; FIR_OUT_SAT_EN selects clamp vs wrap.
module fir_tdm_mac_engine #(
  parameter int IN_W      = 3,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 16,
  parameter int MAX_TAPS  = 40,
  parameter int NUM_MAC   = 4,
  parameter int ADDR_W    = 6,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     iClk12M,
  input  logic                     iRst,
  input  logic                     iEnSample600k,
  input  logic                     iCoeffUpdateFlag,
  input  logic [ADDR_W-1:0]        iAddrRam,
  input  logic signed [COEF_W-1:0] iWrDtRam,
  input  logic [ADDR_W-1:0]        iNumOfCoeff,
  input  logic signed [IN_W-1:0]   iFirIn,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oOverrun
);

  localparam int ACC_W  = IN_W + COEF_W + $clog2(MAX_TAPS) + 1;
  localparam int PROD_W = IN_W + COEF_W;
  localparam int BASE_W = ADDR_W + $clog2(NUM_MAC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [COEF_W-1:0] coeff_q [MAX_TAPS];
  logic signed [COEF_W-1:0] coeff_d [MAX_TAPS];
  logic signed [IN_W-1:0]   x_q [MAX_TAPS];
  logic signed [IN_W-1:0]   x_d [MAX_TAPS];
  logic [ADDR_W-1:0]        nq_q, nq_d;
  logic [BASE_W-1:0]        base_q, base_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  grp_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  out_fmt;
  logic [ADDR_W-1:0]        idx;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  always_comb begin
    state_d = state_q;
    coeff_d = coeff_q;
    x_d     = x_q;
    nq_d    = nq_q;
    base_d  = base_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ovr_d   = 1'b0;
    grp_sum = '0;
    prod    = '0;
    idx     = '0;

    shifted = acc_q >>> OUT_SHIFT;
`ifdef FIR_OUT_SAT_EN
    if (shifted > SAT_MAX)      out_fmt = OUT_W'(SAT_MAX);
    else if (shifted < SAT_MIN) out_fmt = OUT_W'(SAT_MIN);
    else                        out_fmt = OUT_W'(shifted);
`else
    out_fmt = OUT_W'(shifted);
`endif

    if (iCoeffUpdateFlag && (int'(iAddrRam) < MAX_TAPS))
      coeff_d[iAddrRam] = iWrDtRam;

    // Lanes past the latched tap count are masked, so RAM beyond N is never read.
    for (int j = 0; j < NUM_MAC; j++) begin
      if (int'(base_q) + j < int'(nq_q)) begin
        idx     = ADDR_W'(int'(base_q) + j);
        prod    = coeff_q[idx] * x_q[idx];
        grp_sum = grp_sum + ACC_W'(prod);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (iEnSample600k) begin
          if (iCoeffUpdateFlag) begin
            ovr_d = 1'b1;
          end else begin
            x_d[0] = iFirIn;
            for (int k = 1; k < MAX_TAPS; k++) x_d[k] = x_q[k-1];
            nq_d    = (int'(iNumOfCoeff) > MAX_TAPS) ? ADDR_W'(MAX_TAPS) : iNumOfCoeff;
            base_d  = '0;
            acc_d   = '0;
            state_d = (nq_d == '0) ? S_DONE : S_MAC;
          end
        end
      end
      S_MAC: begin
        ovr_d  = iEnSample600k;
        acc_d  = acc_q + grp_sum;
        base_d = base_q + BASE_W'(NUM_MAC);
        if (int'(base_q) + NUM_MAC >= int'(nq_q)) state_d = S_DONE;
        if (iCoeffUpdateFlag) state_d = S_IDLE;
      end
      S_DONE: begin
        ovr_d   = iEnSample600k;
        state_d = S_IDLE;
        if (!iCoeffUpdateFlag) begin
          out_d   = out_fmt;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < MAX_TAPS; i++) begin
        coeff_q[i] <= '0;
        x_q[i]     <= '0;
      end
      nq_q    <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coeff_q <= coeff_d;
      x_q     <= x_d;
      nq_q    <= nq_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign oFirOut  = out_q;
  assign oValid   = valid_q;
  assign oOverrun = ovr_q;
  assign oBusy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_tdm_mac_engine.sv
// Directed bench for fir_tdm_mac_engine: impulses, tap-count edges, overrun, saturation/wrap and abort paths.
module tb_fir_tdm_mac_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               flag;
  logic [5:0]         addr;
  logic signed [15:0] wr;
  logic [5:0]         ncoef;
  logic signed [2:0]  fin;
  logic signed [15:0] fout;
  logic               valid;
  logic               busy;
  logic               ovr;

  int checks = 0;
  int errors = 0;

  int coef [21] = '{13, 0, -19, 24, 0, -37, 48, 0, -102, 206, 500, 206, -102, 0, 48, -37, 0, 24, -19, 0, 13};

`ifdef FIR_OUT_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = -120;
`endif

  fir_tdm_mac_engine dut (
    .iClk12M         (clk),
    .iRst            (rst),
    .iEnSample600k   (en),
    .iCoeffUpdateFlag(flag),
    .iAddrRam        (addr),
    .iWrDtRam        (wr),
    .iNumOfCoeff     (ncoef),
    .iFirIn          (fin),
    .oFirOut         (fout),
    .oValid          (valid),
    .oBusy           (busy),
    .oOverrun        (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input int d);
    flag = 1'b1;
    addr = 6'(a);
    wr   = 16'(d);
    tick();
    flag = 1'b0;
  endtask

  // Strobe one sample, wait for oValid, confirm it drops next cycle, pad to a 20-clock period.
  task automatic run_sample(input int val, output int out, output int lat, output bit pulse_ok);
    en  = 1'b1;
    fin = 3'(val);
    tick();
    en  = 1'b0;
    fin = '0;
    lat = -1;
    out = 0;
    pulse_ok = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (valid) begin
        lat = k;
        out = int'(fout);
      end
    end
    if (lat > 0) begin
      tick();
      pulse_ok = !valid;
      for (int p = lat + 2; p < 20; p++) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; flag = 1'b0; addr = '0; wr = '0; ncoef = '0; fin = '0;
    tick();
    checks++; if (fout !== 16'sd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", fout); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pos_impulse();
    int out, lat, exp;
    bit pok;
    for (int a = 0; a < 21; a++) wr_coef(a, coef[a]);
    for (int a = 21; a < 40; a++) wr_coef(a, 999);
    ncoef = 6'd21;
    for (int i = 0; i < 22; i++) begin
      run_sample((i == 0) ? 1 : 0, out, lat, pok);
      exp = (i < 21) ? coef[i] : 0;
      checks++; if (out !== exp) begin errors++; $display("FAIL pos_out[%0d]: got %0d expected %0d", i, out, exp); end
      checks++; if (lat !== 7) begin errors++; $display("FAIL pos_latency[%0d]: got %0d expected 7", i, lat); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL pos_valid_width[%0d]: got %b expected 1", i, pok); end
    end
  endtask

  task automatic test_neg_impulse();
    int out, lat, exp;
    bit pok;
    for (int i = 0; i < 22; i++) begin
      run_sample((i == 0) ? -4 : 0, out, lat, pok);
      exp = (i < 21) ? -4 * coef[i] : 0;
      checks++; if (out !== exp) begin errors++; $display("FAIL neg_out[%0d]: got %0d expected %0d", i, out, exp); end
      checks++; if (lat !== 7) begin errors++; $display("FAIL neg_latency[%0d]: got %0d expected 7", i, lat); end
    end
  endtask

  // Delay line now holds -4 at x[21]; each strobe pushes it one deeper.
  task automatic test_edge_taps();
    int out, lat;
    bit pok;
    ncoef = 6'd0;
    run_sample(0, out, lat, pok);
    checks++; if (out !== 0) begin errors++; $display("FAIL n0_out: got %0d expected 0", out); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL n0_latency: got %0d expected 1", lat); end
    ncoef = 6'd50;
    run_sample(0, out, lat, pok);
    checks++; if (out !== -3996) begin errors++; $display("FAIL n50_out: got %0d expected -3996", out); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL n50_latency: got %0d expected 11", lat); end
  endtask

  task automatic test_overrun();
    int out, lat, ovr_cnt;
    bit pok;
    ncoef = 6'd21;
    en  = 1'b1;
    fin = 3'sd1;
    tick();
    en  = 1'b0;
    fin = '0;
    lat = -1;
    out = 0;
    ovr_cnt = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (k == 3) begin
        en  = 1'b1;
        fin = 3'sd3;
      end
      tick();
      en  = 1'b0;
      fin = '0;
      if (ovr) ovr_cnt++;
      if (valid) begin
        lat = k;
        out = int'(fout);
      end
    end
    for (int p = 0; p < 12; p++) begin
      tick();
      if (ovr) ovr_cnt++;
    end
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL ovr_latency: got %0d expected 7", lat); end
    checks++; if (out !== 13) begin errors++; $display("FAIL ovr_out: got %0d expected 13", out); end
    run_sample(2, out, lat, pok);
    checks++; if (out !== 26) begin errors++; $display("FAIL ovr_next_out: got %0d expected 26", out); end
    run_sample(0, out, lat, pok);
    checks++; if (out !== -19) begin errors++; $display("FAIL ovr_next2_out: got %0d expected -19", out); end
  endtask

  task automatic test_saturation();
    int out, lat;
    bit pok;
    for (int a = 0; a < 40; a++) wr_coef(a, 32767);
    ncoef = 6'd40;
    out = 0;
    lat = -1;
    for (int i = 0; i < 40; i++) run_sample(3, out, lat, pok);
    checks++; if (out !== SAT_EXP) begin errors++; $display("FAIL sat_out: got %0d expected %0d", out, SAT_EXP); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL sat_latency: got %0d expected 11", lat); end
  endtask

  task automatic test_abort();
    int out, lat, vcnt;
    bit pok;
    // Coefficient write lands mid-MAC (address 63 is outside the RAM).
    en = 1'b1; fin = 3'sd1; tick(); en = 1'b0; fin = '0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mac: got %b expected 1", busy); end
    flag = 1'b1; addr = 6'd63; wr = 16'sd5; tick(); flag = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_flag_idle: got %b expected 0", busy); end
    vcnt = 0;
    for (int p = 0; p < 15; p++) begin tick(); if (valid) vcnt++; end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL abort_flag_valid: got %0d pulses expected 0", vcnt); end
    checks++; if (int'(fout) !== SAT_EXP) begin errors++; $display("FAIL abort_flag_hold: got %0d expected %0d", fout, SAT_EXP); end

    flag = 1'b1; en = 1'b1; addr = 6'd63; tick(); flag = 1'b0; en = 1'b0;
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL flag_strobe_ovr: got %b expected 1", ovr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flag_strobe_busy: got %b expected 0", busy); end
    tick();
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL flag_strobe_ovr_clear: got %b expected 0", ovr); end

    en = 1'b1; fin = 3'sd1; tick(); en = 1'b0; fin = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (fout !== 16'sd0) begin errors++; $display("FAIL rst_mac_out: got %0d expected 0", fout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mac_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mac_valid: got %b expected 0", valid); end
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int p = 0; p < 15; p++) begin tick(); if (valid) vcnt++; end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL rst_mac_no_valid: got %0d pulses expected 0", vcnt); end

    // RAM and delay line must both be cleared: only coeff[0]*x[0] may contribute.
    wr_coef(0, 7);
    wr_coef(2, 100);
    ncoef = 6'd4;
    run_sample(1, out, lat, pok);
    checks++; if (out !== 7) begin errors++; $display("FAIL post_rst_out: got %0d expected 7", out); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL post_rst_latency: got %0d expected 2", lat); end
  endtask

  initial begin
    test_reset();
    test_pos_impulse();
    test_neg_impulse();
    test_edge_taps();
    test_overrun();
    test_saturation();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
